// File: rtl/md_sched_pkg.sv
// md_sched_pkg: shared MIPS op/funct codes and mul/div decode helpers.
// Imported by the md scheduler and its arithmetic datapath.
package md_sched_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Encoding matches funct[1:0] of the multi-cycle ops.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_md_op(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == OP_R) &&
      (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  function automatic logic is_md_class(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == OP_R) &&
      (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                  FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO});
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit product and 32-bit quotient/remainder.
// Operands run 33 bits wide so signed/unsigned share one datapath.
module md_arith
  import md_sched_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_ok
);

  logic               sx;
  logic signed [32:0] sa;
  logic signed [32:0] sb;
  logic signed [32:0] sd;
  logic signed [65:0] p;
  logic signed [32:0] q;
  logic signed [32:0] r;
  logic               unused_top;

  assign sx = (op == MD_MULT) || (op == MD_DIV);
  assign sa = {sx & a[31], a};
  assign sb = {sx & b[31], b};

  assign div_ok = (b != 32'd0);
  // Divisor forced to 1 when zero; the result is discarded anyway.
  assign sd = div_ok ? sb : 33'sd1;

  // 33-bit width lets 0x80000000 / -1 produce +2^31 and wrap cleanly.
  assign p = sa * sb;
  assign q = sa / sd;
  assign r = sa % sd;

  assign prod = p[63:0];
  assign quo  = q[31:0];
  assign rem  = r[31:0];

  assign unused_top = ^{p[65:64], q[32], r[32]};

endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle MULT/DIV scheduler owning HI/LO.
// Fixed-latency FSM plus D-stage stall generation for HI/LO users.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic        valid_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  md_state_e   state_q;
  md_state_e   state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  md_op_e      op_q;

  logic        e_md_op;
  logic        e_mthi;
  logic        e_mtlo;
  logic        d_md;
  logic        done;
  logic        hi_wr;
  logic        lo_wr;
  logic        wr_prod;
  logic        wr_div;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_ok;
  logic        unused_ir;

  assign e_md_op = is_md_op(IR_E[31:26], IR_E[5:0]);
  assign e_mthi  = (IR_E[31:26] == OP_R) && (IR_E[5:0] == FN_MTHI);
  assign e_mtlo  = (IR_E[31:26] == OP_R) && (IR_E[5:0] == FN_MTLO);
  assign d_md    = is_md_class(IR_D[31:26], IR_D[5:0]);

  assign busy     = (state_q == S_BUSY);
  assign start    = valid_E & e_md_op & ~busy;
  assign stall_md = d_md & (start | busy);
  assign done     = busy & (cnt_q == '0);

  assign hi_wr   = valid_E & ~busy & e_mthi;
  assign lo_wr   = valid_E & ~busy & e_mtlo;
  assign wr_prod = done & (op_q inside {MD_MULT, MD_MULTU});
  assign wr_div  = done & (op_q inside {MD_DIV, MD_DIVU}) & div_ok;

  assign unused_ir = ^{IR_D[25:6], IR_E[25:6]};

  md_arith u_arith (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem),
    .div_ok(div_ok)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_MULT;
    end else begin
      state_q <= state_d;
      if (start) begin
        a_q   <= A_E;
        b_q   <= B_E;
        op_q  <= md_op_e'(IR_E[1:0]);
        cnt_q <= IR_E[1] ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
      end else if (busy && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else begin
      unique case (1'b1)
        wr_prod: {HI, LO} <= prod;
        wr_div: begin
          HI <= rem;
          LO <= quo;
        end
        hi_wr:   HI <= A_E;
        lo_wr:   LO <= A_E;
        default: ;
      endcase
    end
  end

  // Hazard unit must keep a second mul/div out of E while busy.
  a_no_restart: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(busy && valid_E && e_md_op)
  );

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: random + directed scoreboard bench for md_sched.
// Reference model uses plain 64-bit arithmetic and a busy window.
module tb_md_sched;
  import md_sched_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR_D = '0;
  logic [31:0] IR_E = '0;
  logic        valid_E = 1'b0;
  logic [31:0] A_E = '0;
  logic [31:0] B_E = '0;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n), .IR_D(IR_D), .IR_E(IR_E),
    .valid_E(valid_E), .A_E(A_E), .B_E(B_E), .start(start),
    .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit st;
    bit bz;
    bit sl;
  } ctl_t;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  ctl_t ctl_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   busy_end = -1;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {OP_R, mid, fn};
  endfunction

  function automatic logic [31:0] mk_other();
    logic [31:0] w;
    w = $urandom;
    if (w[0]) w[31:26] = 6'($urandom_range(1, 63));
    else      w[5:0]   = 6'b100000;
    return w;
  endfunction

  // One pipeline cycle: drive E/D, predict controls and any HI/LO update.
  task automatic issue(input logic [31:0] ie, input logic ve,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] id);
    bit mbusy, eop, st, dmd, mt;
    logic [5:0] fn;
    ctl_t c;
    res_t r;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    IR_E = ie; valid_E = ve; A_E = a; B_E = b; IR_D = id;
    fn = ie[5:0];
    mbusy = (cyc <= busy_end);
    eop = (ie[31:26] == 6'd0) &&
          (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    mt = (ie[31:26] == 6'd0) && (fn inside {FN_MTHI, FN_MTLO});
    dmd = (id[31:26] == 6'd0) &&
          (id[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                           FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO});
    st = ve && eop && !mbusy;
    c.cyc = cyc; c.st = st; c.bz = mbusy; c.sl = dmd && (st || mbusy);
    ctl_q.push_back(c);
    if (st) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (fn == FN_MULT) begin
        p = 64'(sa * sb);
        m_hi = p[63:32]; m_lo = p[31:0];
      end else if (fn == FN_MULTU) begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end else if (b != 0) begin
        if (fn == FN_DIV) begin
          sq = sa / sb; sr = sa % sb;
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      if (fn inside {FN_MULT, FN_MULTU}) busy_end = cyc + ML;
      else                               busy_end = cyc + DL;
      r.due = busy_end + 1; r.hi = m_hi; r.lo = m_lo;
      res_q.push_back(r);
    end else if (ve && mt && !mbusy) begin
      if (fn == FN_MTHI) m_hi = a;
      else               m_lo = a;
      r.due = cyc + 1; r.hi = m_hi; r.lo = m_lo;
      res_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (ctl_q.size() > 0 && ctl_q[0].cyc < cyc) begin
        chk("ctl_missed", 32'(ctl_q[0].cyc), 32'(cyc));
        void'(ctl_q.pop_front());
      end
      if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
        ctl_t c;
        c = ctl_q.pop_front();
        chk("start", 32'(start), 32'(c.st));
        chk("busy", 32'(busy), 32'(c.bz));
        chk("stall_md", 32'(stall_md), 32'(c.sl));
      end
      if (res_q.size() > 0 && res_q[0].due == cyc) begin
        res_t r;
        r = res_q.pop_front();
        chk("HI", HI, r.hi);
        chk("LO", LO, r.lo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nop;
    logic [31:0] mflo;
    logic [5:0]  fns[4];
    logic [5:0]  dfn[8];
    int          k;
    nop = 32'd0;
    mflo = {OP_R, 20'd0, FN_MFLO};
    fns = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    dfn = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO};

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_stall", 32'(stall_md), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(mk(FN_MULT), 1, 32'hFFFF_FFFE, 32'd3, mflo);
    repeat (ML + 1) issue(nop, 1, $urandom, $urandom, mflo);
    issue(mk(FN_MULTU), 1, 32'hFFFF_FFFF, 32'd2, nop);
    repeat (ML + 1) issue(nop, 1, 0, 0, nop);
    issue(mk(FN_DIV), 1, -32'sd7, 32'd2, nop);
    repeat (DL + 1) issue(nop, 1, 0, 0, nop);
    issue(mk(FN_DIVU), 1, 32'd7, 32'd0, nop);
    repeat (DL + 1) issue(nop, 1, 0, 0, nop);
    issue(mk(FN_MTLO), 1, 32'h1234, 0, nop);
    issue(nop, 1, 0, 0, nop);
    issue(mk(FN_MTLO), 0, 32'h5555, 0, nop);
    issue(nop, 1, 0, 0, nop);
    issue(mk(FN_DIV), 1, 32'h8000_0000, 32'hFFFF_FFFF, nop);
    repeat (DL + 1) issue(nop, 1, 0, 0, nop);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ie, id, a, b;
      logic        ve;
      k = $urandom_range(0, 9);
      ve = ($urandom_range(0, 7) != 0);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (k < 4)      ie = mk(fns[k]);
      else if (k < 6) ie = mk((k == 4) ? FN_MTHI : FN_MTLO);
      else            ie = mk_other();
      if (k < 6 && cyc <= busy_end) ve = 1'b0;
      if ($urandom_range(0, 1) == 1) id = mk(dfn[$urandom_range(0, 7)]);
      else                           id = mk_other();
      issue(ie, ve, a, b, id);
    end

    for (int i = 0; i < 40 && (res_q.size() > 0 || cyc <= busy_end); i++)
      issue(nop, 1, 0, 0, nop);
    issue(nop, 1, 0, 0, nop);
    chk("drain_res", 32'(res_q.size()), 32'd0);
    mon_en = 1'b0;
    ctl_q.delete();

    IR_D = nop;
    IR_E = mk(FN_MTHI); valid_E = 1; A_E = 32'hA5A5_0001;
    @(posedge clk); #1;
    IR_E = mk(FN_MTLO); A_E = 32'h5A5A_0002;
    @(posedge clk); #1;
    chk("pre_hi", HI, 32'hA5A5_0001);
    chk("pre_lo", LO, 32'h5A5A_0002);
    IR_E = mk(FN_DIV); A_E = -32'sd7; B_E = 32'd2;
    @(posedge clk); #1;
    valid_E = 0;
    chk("div_busy1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (DL + 4) @(posedge clk);
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_hi", HI, 32'd0);
    chk("post_lo", LO, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
